// File: rtl/v_table_ctrl_pkg.sv
// Shared types and constants for the state table and its controller.
package v_pkg;

  localparam int unsigned CONTEXT_N = 64;

  typedef logic [$clog2(CONTEXT_N)-1:0] addr_t;
  typedef logic [7:0]                   state_t;

  localparam state_t INIT_VAL = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    INIT  = 2'd2
  } tbl_ctrl_state_t;

endpackage

// File: rtl/v_table_ctrl.sv
// State-table lifecycle controller: init sweep, pre-sweep pipeline drain,
// and arbitration of the shared table write port.
module v_table_ctrl
  import v_pkg::*;
#(
  parameter int unsigned  N        = CONTEXT_N,
  parameter int unsigned  W        = $bits(state_t),
  parameter logic [W-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_init_req,
  input  logic [3:0]           i_pipe_vld,
  input  logic                 i_state_wen,
  input  logic [$clog2(N)-1:0] i_state_waddr,
  input  logic [W-1:0]         i_state_wdata,
  output logic                 o_wen,
  output logic [$clog2(N)-1:0] o_waddr,
  output logic [W-1:0]         o_wdata,
  output logic                 o_upd_accept,
  output logic                 o_lut_accept,
  output logic                 o_busy_r,
  output logic                 o_init_done_r,
  output logic                 o_wr_drop_r
);

  localparam int unsigned     AW   = $clog2(N);
  localparam logic [AW-1:0]   LAST = AW'(N - 1);

  tbl_ctrl_state_t state_r;
  tbl_ctrl_state_t state_nxt;
  logic [AW-1:0]   cnt_r;
  logic            sweep_last;

  assign sweep_last = (state_r == INIT) && (cnt_r == LAST);

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (i_init_req) state_nxt = DRAIN;
      // The cycle that sees an empty pipeline still carries no write, so
      // leaving here cannot cut off an in-flight write-back.
      DRAIN:   if ((i_pipe_vld == 4'd0) && !i_state_wen) state_nxt = INIT;
      INIT:    if (cnt_r == LAST) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= INIT;
      cnt_r         <= '0;
      o_busy_r      <= 1'b1;
      o_init_done_r <= 1'b0;
      o_wr_drop_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      o_busy_r      <= (state_nxt != IDLE);
      o_init_done_r <= sweep_last;
      // Explicit wrap keeps the counter in range for non-power-of-two N.
      if (state_r == INIT)
        cnt_r <= (cnt_r == LAST) ? '0 : cnt_r + 1'b1;
      else
        cnt_r <= '0;
      if ((state_r == INIT) && i_state_wen)
        o_wr_drop_r <= 1'b1;
    end
  end

  always_comb begin
    o_wen   = 1'b0;
    o_waddr = i_state_waddr;
    o_wdata = i_state_wdata;
    if (!rst) begin
      if (state_r == INIT) begin
        o_wen   = 1'b1;
        o_waddr = cnt_r;
        o_wdata = INIT_VAL;
      end else begin
        o_wen   = i_state_wen;
      end
    end
  end

  assign o_upd_accept = (state_r == IDLE) && !i_init_req && !rst;
  assign o_lut_accept = o_upd_accept;

endmodule

// File: tb/tb_v_table_ctrl.sv
// Directed bench for v_table_ctrl with N=8, W=8, INIT_VAL=0.
module tb_v_table_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          init_req;
  logic [3:0]    pipe_vld;
  logic          state_wen;
  logic [AW-1:0] state_waddr;
  logic [W-1:0]  state_wdata;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic          upd_accept;
  logic          lut_accept;
  logic          busy;
  logic          init_done;
  logic          wr_drop;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  v_table_ctrl #(
    .N        (N),
    .W        (W),
    .INIT_VAL (8'h00)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_init_req    (init_req),
    .i_pipe_vld    (pipe_vld),
    .i_state_wen   (state_wen),
    .i_state_waddr (state_waddr),
    .i_state_wdata (state_wdata),
    .o_wen         (wen),
    .o_waddr       (waddr),
    .o_wdata       (wdata),
    .o_upd_accept  (upd_accept),
    .o_lut_accept  (lut_accept),
    .o_busy_r      (busy),
    .o_init_done_r (init_done),
    .o_wr_drop_r   (wr_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // at the falling edge.
  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic sweep_chk(input int unsigned k);
    chk($sformatf("sweep%0d_wen", k), 32'(wen), 32'd1);
    chk($sformatf("sweep%0d_waddr", k), 32'(waddr), 32'(k));
    chk($sformatf("sweep%0d_wdata", k), 32'(wdata), 32'h00);
    chk($sformatf("sweep%0d_busy", k), 32'(busy), 32'd1);
    chk($sformatf("sweep%0d_upd_acc", k), 32'(upd_accept), 32'd0);
    chk($sformatf("sweep%0d_lut_acc", k), 32'(lut_accept), 32'd0);
    chk($sformatf("sweep%0d_done", k), 32'(init_done), 32'd0);
  endtask

  task automatic done_chk(input string tag, input logic exp_drop);
    chk({tag, "_done"}, 32'(init_done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_upd_acc"}, 32'(upd_accept), 32'd1);
    chk({tag, "_lut_acc"}, 32'(lut_accept), 32'd1);
    chk({tag, "_wen"}, 32'(wen), 32'd0);
    chk({tag, "_drop"}, 32'(wr_drop), 32'(exp_drop));
  endtask

  initial begin
    rst = 1'b1; init_req = 1'b0; pipe_vld = 4'd0;
    state_wen = 1'b0; state_waddr = '0; state_wdata = '0;

    // Reset state, including a write attempt that must be masked.
    advance(); advance();
    state_wen = 1'b1; state_waddr = 3'd1; state_wdata = 8'hEE;
    sample();
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_drop", 32'(wr_drop), 32'd0);
    chk("rst_upd_acc", 32'(upd_accept), 32'd0);
    chk("rst_lut_acc", 32'(lut_accept), 32'd0);

    // Power-on sweep: addresses 0..7 in cycles 0..7, done in cycle 8.
    advance();
    rst = 1'b0; state_wen = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (k != 0) advance();
      sample();
      sweep_chk(k);
    end
    advance();
    sample();
    done_chk("boot", 1'b0);
    advance();
    sample();
    chk("boot_done_single", 32'(init_done), 32'd0);

    // IDLE pass-through with zero latency.
    state_wen = 1'b1; state_waddr = 3'd5; state_wdata = 8'hAB;
    #1;
    chk("idle_wen", 32'(wen), 32'd1);
    chk("idle_waddr", 32'(waddr), 32'd5);
    chk("idle_wdata", 32'(wdata), 32'hAB);

    // Re-init with a busy pipeline: refused on the request cycle itself.
    advance();
    state_wen = 1'b0; pipe_vld = 4'b0011; init_req = 1'b1;
    sample();
    chk("req_upd_acc", 32'(upd_accept), 32'd0);
    chk("req_lut_acc", 32'(lut_accept), 32'd0);
    chk("req_busy", 32'(busy), 32'd0);
    advance();
    init_req = 1'b0;
    sample();
    chk("drain0_busy", 32'(busy), 32'd1);
    chk("drain0_wen", 32'(wen), 32'd0);
    chk("drain0_upd_acc", 32'(upd_accept), 32'd0);
    advance();
    pipe_vld = 4'b0001; state_wen = 1'b1; state_waddr = 3'd3; state_wdata = 8'h11;
    sample();
    chk("drain1_wen", 32'(wen), 32'd1);
    chk("drain1_waddr", 32'(waddr), 32'd3);
    chk("drain1_wdata", 32'(wdata), 32'h11);
    advance();
    pipe_vld = 4'b0000; state_waddr = 3'd4; state_wdata = 8'h22;
    sample();
    chk("drain2_wen", 32'(wen), 32'd1);
    chk("drain2_waddr", 32'(waddr), 32'd4);
    chk("drain2_wdata", 32'(wdata), 32'h22);
    advance();
    state_wen = 1'b0;
    sample();
    chk("drain3_wen", 32'(wen), 32'd0);
    chk("drain3_busy", 32'(busy), 32'd1);

    // Sweep with a discarded update write at k=2 and an ignored request at k=3.
    for (int unsigned k = 0; k < N; k++) begin
      advance();
      state_wen = 1'b0; init_req = 1'b0;
      if (k == 2) begin
        state_wen = 1'b1; state_waddr = 3'd6; state_wdata = 8'h55;
      end
      if (k == 3) init_req = 1'b1;
      sample();
      sweep_chk(k);
      if (k == 3) chk("drop_set", 32'(wr_drop), 32'd1);
    end
    advance();
    init_req = 1'b0;
    sample();
    done_chk("reinit", 1'b1);
    advance();
    sample();
    chk("reinit_done_single", 32'(init_done), 32'd0);
    chk("reinit_drop_sticky", 32'(wr_drop), 32'd1);

    // Empty pipeline: exactly one DRAIN cycle, then reset at sweep cycle 5.
    init_req = 1'b1;
    advance();
    init_req = 1'b0;
    sample();
    chk("drain_only_busy", 32'(busy), 32'd1);
    chk("drain_only_wen", 32'(wen), 32'd0);
    for (int unsigned k = 0; k < 5; k++) begin
      advance();
      sample();
      sweep_chk(k);
    end
    advance();
    rst = 1'b1;
    sample();
    chk("midrst_wen", 32'(wen), 32'd0);
    chk("midrst_drop_before", 32'(wr_drop), 32'd1);
    chk("midrst_upd_acc", 32'(upd_accept), 32'd0);
    advance();
    rst = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (k != 0) advance();
      sample();
      sweep_chk(k);
      if (k == 0) chk("midrst_drop_cleared", 32'(wr_drop), 32'd0);
    end
    advance();
    sample();
    done_chk("restart", 1'b0);
    advance();
    sample();
    chk("restart_done_single", 32'(init_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
